// File: rtl/aes_sub_bytes_iter_if.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_iter_if
// Handshake bundle for the iterative forward SubBytes engine.
//   in_valid  : producer has a 128-bit state on in_data
//   in_ready  : engine can accept a new state (engine is idle)
//   in_data   : input state, byte k = bits [8k+7:8k]
//   out_valid : out_data holds a completed substituted state
//   out_ready : consumer accepts the result
//   out_data  : substituted state, same byte order as in_data
//   busy      : engine is substituting bytes
// Modports: master = producer/consumer side, slave = engine side.
// ---------------------------------------------------------------------------
interface aes_sub_bytes_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// aes_sub_bytes_iter
// Iterative forward AES SubBytes: a captured 128-bit state is substituted
// through the forward S-box LANES bytes per cycle, then offered on the output
// handshake. One block in flight at a time.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : aes_sub_bytes_iter_if.slave (in/out handshakes, data, busy)
// Parameter:
//   LANES : bytes substituted per cycle, one of 1, 2, 4, 8, 16
// Optional build macro:
//   SUB_BYTES_PIPE_EN : register S-box outputs before write-back (adds a
//                       DRAIN state and one cycle of latency)
// ---------------------------------------------------------------------------
module aes_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input logic           clk,
  input logic           rst,
  aes_sub_bytes_iter_if.slave bus
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // LANES=16 truncates to 0, so the counter stays at 0 for the single RUN cycle.
  localparam logic [3:0] LANE_STEP = 4'(LANES);
  localparam logic [3:0] LAST_IDX  = 4'(16 - LANES);

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [10:0] pos;
    pos = {8'hff - x, 3'b000};
    sbox_fwd = SBOX_TABLE[pos +: 8];
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0][7:0]      r_work;
  logic [3:0]            r_cnt;
  logic                  r_out_valid;
  logic                  w_in_ready;
  logic                  w_busy;
  logic                  w_last;
  logic [LANES-1:0][7:0] w_sub;

  assign w_last = (r_cnt == LAST_IDX);

`ifdef SUB_BYTES_PIPE_EN
  logic [LANES-1:0][7:0] r_pipe;
  logic [3:0]            w_wb_idx;
  // The registered group always belongs to the previous counter value; in
  // DRAIN it is the final group.
  assign w_wb_idx = (r_state == ST_DRAIN) ? LAST_IDX : (r_cnt - LANE_STEP);
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus in_ready/busy decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
`ifdef SUB_BYTES_PIPE_EN
          w_state_nxt = ST_DRAIN;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // S-box lookup of the lane group selected by the byte counter.
  always_comb begin
    w_sub = {(LANES*8){1'b0}};
    for (int l = 0; l < LANES; l++) begin
      w_sub[l] = sbox_fwd(r_work[r_cnt + 4'(l)]);
    end
  end

  // Work register, byte counter and out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work      <= 128'h0;
      r_cnt       <= 4'h0;
      r_out_valid <= 1'b0;
`ifdef SUB_BYTES_PIPE_EN
      r_pipe      <= {(LANES*8){1'b0}};
`endif
    end else begin
      r_out_valid <= (w_state_nxt == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_work <= bus.in_data;
            r_cnt  <= 4'h0;
          end
        end
        ST_RUN: begin
`ifdef SUB_BYTES_PIPE_EN
          r_pipe <= w_sub;
          if (r_cnt != 4'h0) begin
            for (int l = 0; l < LANES; l++) begin
              r_work[w_wb_idx + 4'(l)] <= r_pipe[l];
            end
          end
`else
          for (int l = 0; l < LANES; l++) begin
            r_work[r_cnt + 4'(l)] <= w_sub[l];
          end
`endif
          // Hold on the last group so the counter never wraps inside a block.
          if (!w_last) begin
            r_cnt <= r_cnt + LANE_STEP;
          end
        end
        ST_DRAIN: begin
`ifdef SUB_BYTES_PIPE_EN
          for (int l = 0; l < LANES; l++) begin
            r_work[w_wb_idx + 4'(l)] <= r_pipe[l];
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.busy      = w_busy;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_work;

endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// ---------------------------------------------------------------------------
// tb_aes_sub_bytes_iter
// Bench for aes_sub_bytes_iter. Five engines (LANES 4, 1, 2, 8, 16) share
// clk/rst; each has its own interface instance. Expected results come from a
// GF(2^8) inverse + affine-transform model of the S-box built at time 0.
// ---------------------------------------------------------------------------
module tb_aes_sub_bytes_iter;

  localparam int NDUT = 5;
  localparam int LANES_TAB [NDUT] = '{4, 1, 2, 8, 16};
`ifdef SUB_BYTES_PIPE_EN
  localparam int PIPE_LAT = 1;
`else
  localparam int PIPE_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NDUT-1:0]        in_valid_v;
  logic [NDUT-1:0]        in_ready_v;
  logic [NDUT-1:0]        out_valid_v;
  logic [NDUT-1:0]        out_ready_v;
  logic [NDUT-1:0]        busy_v;
  logic [NDUT-1:0][127:0] in_data_v;
  logic [NDUT-1:0][127:0] out_data_v;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] sbox_m [256];
  logic [7:0] inv_m  [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    aes_sub_bytes_iter_if bus ();
    assign bus.in_valid   = in_valid_v[g];
    assign bus.in_data    = in_data_v[g];
    assign bus.out_ready  = out_ready_v[g];
    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign out_data_v[g]  = bus.out_data;
    assign busy_v[g]      = bus.busy;
    aes_sub_bytes_iter #(.LANES(LANES_TAB[g])) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] y);
    return rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05;
  endfunction

  function automatic logic [127:0] sub_model(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_m[s[8*k +: 8]];
    return r;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge just after the accept edge.
  task automatic start_block(input int d, input logic [127:0] data);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready_v[d] && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 128'(in_ready_v[d]), 128'h1);
    in_valid_v[d] = 1'b1;
    in_data_v[d]  = data;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[d] = 1'b0;
    in_data_v[d]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Starts at the falling edge after the accept edge; checks latency, data,
  // then completes the output transfer.
  task automatic wait_result(input int d, input logic [127:0] exp, input string tag,
                             output logic [127:0] got);
    int lat;
    int exp_lat;
    lat     = 0;
    exp_lat = 16 / LANES_TAB[d] + PIPE_LAT;
    check({tag, "_busy"}, 128'(busy_v[d]), 128'h1);
    check({tag, "_inready_lo"}, 128'(in_ready_v[d]), 128'h0);
    while (!out_valid_v[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_data"}, out_data_v[d], exp);
    got = out_data_v[d];
    out_ready_v[d] = 1'b1;
    @(negedge clk);
    out_ready_v[d] = 1'b0;
    check({tag, "_ovalid_lo"}, 128'(out_valid_v[d]), 128'h0);
    check({tag, "_inready_hi"}, 128'(in_ready_v[d]), 128'h1);
  endtask

  // ---------------- stimulus ----------------
  logic [127:0] fips_in;
  logic [127:0] fips_out;
  logic [127:0] blk, got, rec, a_blk, b_blk, exp_a;
  logic [127:0] sweep_out [16];
  int lat;

  initial begin
    for (int x = 0; x < 256; x++) begin
      sbox_m[x] = affine(ginv(8'(x)));
      inv_m[x]  = ginv(inv_affine(8'(x)));
    end
    fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    fips_out = 128'hd42711aee0bf98f1b8b45de51e415230;

    in_valid_v  = '0;
    out_ready_v = '0;
    in_data_v   = '0;

    // Reset held for 3 cycles.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("rst_inready_l%0d", LANES_TAB[d]), 128'(in_ready_v[d]), 128'h1);
      check($sformatf("rst_ovalid_l%0d", LANES_TAB[d]), 128'(out_valid_v[d]), 128'h0);
      check($sformatf("rst_odata_l%0d", LANES_TAB[d]), out_data_v[d], 128'h0);
      check($sformatf("rst_busy_l%0d", LANES_TAB[d]), 128'(busy_v[d]), 128'h0);
    end

    // FIPS-197 round-1 vector through every lane width.
    for (int d = 0; d < NDUT; d++) begin
      start_block(d, fips_in);
      wait_result(d, fips_out, $sformatf("fips_l%0d", LANES_TAB[d]), got);
    end

    // Full table sweep on the 16-lane engine.
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) blk[8*k +: 8] = 8'(16 * b + k);
      start_block(4, blk);
      wait_result(4, sub_model(blk), $sformatf("sweep%0d", b), got);
      sweep_out[b] = got;
      for (int k = 0; k < 16; k++) rec[8*k +: 8] = inv_m[got[8*k +: 8]];
      check($sformatf("sweep_inverse%0d", b), rec, blk);
    end
    check("s_00", 128'(sweep_out[0][7:0]), 128'h63);
    check("s_01", 128'(sweep_out[0][15:8]), 128'h7c);
    check("s_53", 128'(sweep_out[5][31:24]), 128'hed);
    check("s_ff", 128'(sweep_out[15][127:120]), 128'h16);

    // Random blocks on every engine.
    for (int r = 0; r < 15; r++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      start_block(r % NDUT, blk);
      wait_result(r % NDUT, sub_model(blk), $sformatf("rand%0d", r), got);
    end

    // Backpressure on the 4-lane engine; a new in_valid during DONE is ignored.
    a_blk = {$urandom, $urandom, $urandom, $urandom};
    b_blk = {$urandom, $urandom, $urandom, $urandom};
    exp_a = sub_model(a_blk);
    start_block(0, a_blk);
    lat = 0;
    while (!out_valid_v[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 128'(lat), 128'(4 + PIPE_LAT));
    in_valid_v[0] = 1'b1;
    in_data_v[0]  = b_blk;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold_ovalid%0d", i), 128'(out_valid_v[0]), 128'h1);
      check($sformatf("bp_hold_data%0d", i), out_data_v[0], exp_a);
      check($sformatf("bp_hold_inready%0d", i), 128'(in_ready_v[0]), 128'h0);
      @(negedge clk);
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    check("bp_xfer_ovalid", 128'(out_valid_v[0]), 128'h0);
    check("bp_xfer_inready", 128'(in_ready_v[0]), 128'h1);
    check("bp_xfer_busy", 128'(busy_v[0]), 128'h0);
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    wait_result(0, sub_model(b_blk), "bp_next", got);

    // Reset after two RUN cycles, then a clean block.
    blk = {$urandom, $urandom, $urandom, $urandom};
    start_block(0, blk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_inready", 128'(in_ready_v[0]), 128'h1);
    check("mid_rst_ovalid", 128'(out_valid_v[0]), 128'h0);
    check("mid_rst_odata", out_data_v[0], 128'h0);
    check("mid_rst_busy", 128'(busy_v[0]), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_ovalid", 128'(out_valid_v[0]), 128'h0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    start_block(0, blk);
    wait_result(0, sub_model(blk), "post_rst", got);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
